cfu_mac_sched: RTL

Command-driven scheduler for the 4-lane int8 SIMD multiply-accumulate datapath inside the CFU. It accepts CPU custom-instruction commands over the CFU cmd/rsp handshake. It buffers operand word pairs in a small FIFO and issues them one per cycle into a pipelined dot-product unit. It also sequences offset configuration, accumulator clear and result readback so that no command observes a half-drained pipeline.

---
 rtl/cfu_mac_pkg.sv | 19 +
 rtl/simd_mac4.sv | 53 +++++
 rtl/cfu_mac_sched.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cfu_mac_pkg.sv
// Shared constants and types for the CFU MAC scheduler and its SIMD datapath.
package cfu_mac_pkg;

    localparam int ACC_W = 32;
    localparam int OFF_W = 9;

    localparam logic [2:0] FN_SET_OFF = 3'd0;
    localparam logic [2:0] FN_CLEAR   = 3'd1;
    localparam logic [2:0] FN_PUSH    = 3'd2;
    localparam logic [2:0] FN_READ    = 3'd3;
    localparam logic [2:0] FN_RUN     = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RSP
    } state_e;

endpackage

// File: rtl/simd_mac4.sv
// Four-lane int8 dot product: registered offset-adjusted lane products, then a
// combinational lane sum that the scheduler folds into its accumulator register.
module simd_mac4
    import cfu_mac_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [OFF_W-1:0] input_offset,
    input  logic [OFF_W-1:0] filter_offset,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_sum
);

    logic [3:0][19:0] prod_d, prod_q;
    logic             valid_d, valid_q;
    logic signed [9:0] fa [4];
    logic signed [9:0] fb [4];

    always_comb begin
        valid_d = in_valid;
        prod_d  = prod_q;
        for (int i = 0; i < 4; i++) begin
            fa[i] = 10'($signed(in_a[8*i +: 8])) + 10'($signed(input_offset));
            fb[i] = 10'($signed(in_b[8*i +: 8])) + 10'($signed(filter_offset));
            if (in_valid) begin
                prod_d[i] = 20'(fa[i]) * 20'(fb[i]);
            end
        end
    end

    always_comb begin
        out_sum = '0;
        for (int i = 0; i < 4; i++) begin
            out_sum = out_sum + ACC_W'($signed(prod_q[i]));
        end
    end

    assign out_valid = valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            prod_q  <= '0;
        end else begin
            valid_q <= valid_d;
            prod_q  <= prod_d;
        end
    end

endmodule

// File: rtl/cfu_mac_sched.sv
// Command scheduler for the CFU int8 MAC: operand FIFO, issue into simd_mac4,
// and drain sequencing so offset/clear/read/run never see a half-drained pipeline.
//
// state | meaning
// IDLE  | ready for a command (PUSH blocked only while the FIFO is full)
// WAIT  | drain-type command latched, waiting for pipeline (and FIFO if running) to empty
// RSP   | response presented, held until rsp_ready
module cfu_mac_sched
    import cfu_mac_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    state_e           state_q, state_d;
    logic [2:0]       fn_q, fn_d;
    logic [OFF_W-1:0] arg0_q, arg0_d, arg1_q, arg1_d;
    logic [OFF_W-1:0] in_off_q, in_off_d, f_off_q, f_off_d;
    logic             run_q, run_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ACC_W-1:0] rsp_data_q, rsp_data_d;

    logic [63:0]      mem_q [FIFO_DEPTH];
    logic [63:0]      mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [2:0]       fn_in;
    logic             fire, push, pop, full, empty, drain_ok;
    logic             mac_valid;
    logic [ACC_W-1:0] mac_sum;
    logic [63:0]      pop_data;
    logic             unused_fn_hi;

    assign fn_in        = cmd_payload_function_id[2:0];
    assign unused_fn_hi = ^cmd_payload_function_id[9:3];
    assign full         = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty        = (count_q == '0);
    // Gated on the live funct3 so RUN can still get in while the FIFO is full.
    assign cmd_ready    = (state_q == IDLE) && !(full && (fn_in == FN_PUSH));
    assign fire         = cmd_valid && cmd_ready;
    assign push         = fire && (fn_in == FN_PUSH);
    assign pop          = run_q && !empty;
    assign pop_data     = mem_q[rd_ptr_q];
    assign drain_ok     = !mac_valid && (!run_q || empty);

    simd_mac4 u_mac (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (pop),
        .in_a          (pop_data[63:32]),
        .in_b          (pop_data[31:0]),
        .input_offset  (in_off_q),
        .filter_offset (f_off_q),
        .out_valid     (mac_valid),
        .out_sum       (mac_sum)
    );

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {cmd_payload_inputs_0, cmd_payload_inputs_1};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        fn_d        = fn_q;
        arg0_d      = arg0_q;
        arg1_d      = arg1_q;
        in_off_d    = in_off_q;
        f_off_d     = f_off_q;
        run_d       = run_q;
        acc_d       = mac_valid ? (acc_q + mac_sum) : acc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;

        unique case (state_q)
            IDLE: begin
                if (fire) begin
                    fn_d   = fn_in;
                    arg0_d = cmd_payload_inputs_0[OFF_W-1:0];
                    arg1_d = cmd_payload_inputs_1[OFF_W-1:0];
                    case (fn_in)
                        FN_SET_OFF, FN_CLEAR, FN_READ, FN_RUN: begin
                            state_d = WAIT;
                        end
                        FN_PUSH: begin
                            state_d     = RSP;
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = ACC_W'(count_q);
                        end
                        default: begin
                            state_d     = RSP;
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = '0;
                        end
                    endcase
                end
            end
            WAIT: begin
                if (drain_ok) begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    case (fn_q)
                        FN_SET_OFF: begin
                            in_off_d = arg0_q;
                            f_off_d  = arg1_q;
                        end
                        FN_CLEAR: acc_d      = '0;
                        FN_READ:  rsp_data_d = acc_q;
                        FN_RUN:   run_d      = arg0_q[0];
                        default:  ;
                    endcase
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_valid             = rsp_valid_q;
    assign rsp_payload_outputs_0 = rsp_data_q;

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            fn_q        <= '0;
            arg0_q      <= '0;
            arg1_q      <= '0;
            in_off_q    <= '0;
            f_off_q     <= '0;
            run_q       <= 1'b0;
            acc_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fn_q        <= fn_d;
            arg0_q      <= arg0_d;
            arg1_q      <= arg1_d;
            in_off_q    <= in_off_d;
            f_off_q     <= f_off_d;
            run_q       <= run_d;
            acc_q       <= acc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

endmodule
